// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive-side controller.
package uart_pkg;

  typedef enum logic {
    S_OFF,
    S_ON
  } state_e;

  localparam int unsigned MIN_BAUD = 4;
  localparam int unsigned DEPTH    = 8;

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Read-side bus port of the receive FIFO: pop request, head data, valid and occupancy.
interface uart_rx_ctrl_if #(
  parameter int unsigned AW = 3
);

  logic          rd_req_i;
  logic [7:0]    rd_data_o;
  logic          rd_valid_o;
  logic [AW:0]   level_o;

  modport master (
    output rd_req_i,
    input  rd_data_o,
    input  rd_valid_o,
    input  level_o
  );

  modport slave (
    input  rd_req_i,
    output rd_data_o,
    output rd_valid_o,
    output level_o
  );

endinterface

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through byte FIFO; a push at full is accepted only alongside a pop.
module uart_rx_fifo #(
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic [7:0]  din,
  input  logic        pop,
  output logic [7:0]  dout,
  output logic        full,
  output logic        empty,
  output logic [AW:0] level
);

  localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   cnt;
  logic          push_ok;
  logic          pop_ok;

  assign empty   = (cnt == '0);
  assign full    = (cnt == FULL_LVL);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign level   = cnt;
  // Head is forced to zero while empty so stale entries never leak out.
  assign dout    = empty ? '0 : mem[rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop_ok)  rptr <= rptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= din;
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Receive controller: enable FSM with baud shadow, byte FIFO, watermark/overflow/timeout interrupts.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = uart_pkg::DEPTH,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 cfg_en_i,
  input  logic [15:0]          cfg_baud_i,
  input  logic [AW:0]          cfg_wmark_i,
  input  logic [7:0]           cfg_timeout_i,
  input  logic [1:0]           clr_i,
  output logic                 rx_en_o,
  output logic [15:0]          clks_per_bit_o,
  input  logic                 rx_dv_i,
  input  logic [7:0]           rx_byte_i,
  uart_rx_ctrl_if.slave        rd,
  output logic                 intr_wmark_o,
  output logic                 intr_overflow_o,
  output logic                 intr_timeout_o
);

  state_e      state;
  logic        full;
  logic        empty;
  logic        pop_ok;
  logic        drop;
  logic [AW:0] level;
  logic [7:0]  head;
  logic [15:0] presc;
  logic [7:0]  bit_cnt;
  logic        tmr_clr;
  logic        wrap;
  logic        fire;

  uart_rx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .push  (rx_dv_i),
    .din   (rx_byte_i),
    .pop   (rd.rd_req_i),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  assign rd.rd_data_o  = head;
  assign rd.rd_valid_o = !empty;
  assign rd.level_o    = level;

  assign pop_ok       = rd.rd_req_i && !empty;
  assign drop         = rx_dv_i && full && !pop_ok;
  assign intr_wmark_o = (cfg_wmark_i != '0) && (level >= cfg_wmark_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state          <= S_OFF;
      rx_en_o        <= 1'b0;
      clks_per_bit_o <= '0;
    end else begin
      case (state)
        S_OFF: begin
          clks_per_bit_o <= cfg_baud_i;
          if (cfg_en_i && (cfg_baud_i >= 16'(MIN_BAUD))) begin
            state   <= S_ON;
            rx_en_o <= 1'b1;
          end
        end
        S_ON: begin
          if (!cfg_en_i) begin
            state   <= S_OFF;
            rx_en_o <= 1'b0;
          end
        end
        default: begin
          state   <= S_OFF;
          rx_en_o <= 1'b0;
        end
      endcase
    end
  end

  // Timeout fires on the increment that reaches the threshold, so it is edge-like
  // per idle period without a separate arm flag; a saturated counter never re-fires.
  assign tmr_clr = rx_dv_i || pop_ok || empty;
  assign wrap    = (presc == clks_per_bit_o - 16'd1);
  assign fire    = !tmr_clr && wrap && (bit_cnt != '1) && (cfg_timeout_i != '0)
                   && ((bit_cnt + 8'd1) == cfg_timeout_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      presc   <= '0;
      bit_cnt <= '0;
    end else if (tmr_clr) begin
      presc   <= '0;
      bit_cnt <= '0;
    end else if (wrap) begin
      presc <= '0;
      if (bit_cnt != '1) bit_cnt <= bit_cnt + 8'd1;
    end else begin
      presc <= presc + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      intr_overflow_o <= 1'b0;
      intr_timeout_o  <= 1'b0;
    end else begin
      if (drop)          intr_overflow_o <= 1'b1;
      else if (clr_i[0]) intr_overflow_o <= 1'b0;
      if (fire)          intr_timeout_o  <= 1'b1;
      else if (clr_i[1]) intr_timeout_o  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl with DEPTH=8 and hand-computed expectations.
module tb_uart_rx_ctrl;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        cfg_en = 1'b0;
  logic [15:0] cfg_baud = '0;
  logic [3:0]  cfg_wmark = '0;
  logic [7:0]  cfg_timeout = '0;
  logic [1:0]  clr = '0;
  logic        rx_en;
  logic [15:0] cpb;
  logic        rx_dv = 1'b0;
  logic [7:0]  rx_byte = '0;
  logic        intr_wmark;
  logic        intr_overflow;
  logic        intr_timeout;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  uart_rx_ctrl_if #(.AW(3)) rd_bus ();

  uart_rx_ctrl #(.DEPTH(8)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_ni),
    .cfg_en_i        (cfg_en),
    .cfg_baud_i      (cfg_baud),
    .cfg_wmark_i     (cfg_wmark),
    .cfg_timeout_i   (cfg_timeout),
    .clr_i           (clr),
    .rx_en_o         (rx_en),
    .clks_per_bit_o  (cpb),
    .rx_dv_i         (rx_dv),
    .rx_byte_i       (rx_byte),
    .rd              (rd_bus),
    .intr_wmark_o    (intr_wmark),
    .intr_overflow_o (intr_overflow),
    .intr_timeout_o  (intr_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic dv, input logic [7:0] b, input logic rq, input logic [1:0] c);
    @(negedge clk);
    rx_dv = dv;
    rx_byte = b;
    rd_bus.rd_req_i = rq;
    clr = c;
    @(posedge clk);
    #1;
    rx_dv = 1'b0;
    rd_bus.rd_req_i = 1'b0;
    clr = '0;
  endtask

  task automatic set_cfg(input logic en, input logic [15:0] baud);
    @(negedge clk);
    cfg_en = en;
    cfg_baud = baud;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rd_bus.rd_req_i = 1'b0;

    // Reset state
    idle(2);
    chk("rst_rx_en", 32'(rx_en), 0);
    chk("rst_cpb", 32'(cpb), 0);
    chk("rst_level", 32'(rd_bus.level_o), 0);
    chk("rst_valid", 32'(rd_bus.rd_valid_o), 0);
    chk("rst_data", 32'(rd_bus.rd_data_o), 0);
    chk("rst_intr", 32'({intr_wmark, intr_overflow, intr_timeout}), 0);
    @(negedge clk);
    rst_ni = 1'b1;

    // Enable and baud shadow
    set_cfg(1'b1, 16'd87);
    chk("en_rx_en", 32'(rx_en), 1);
    chk("en_cpb", 32'(cpb), 87);
    set_cfg(1'b1, 16'd20);
    idle(2);
    chk("frozen_cpb", 32'(cpb), 87);
    set_cfg(1'b0, 16'd20);
    chk("dis_rx_en", 32'(rx_en), 0);
    chk("dis_cpb_hold", 32'(cpb), 87);
    idle(1);
    chk("dis_cpb_load", 32'(cpb), 20);

    // Baud below minimum keeps the receiver off
    set_cfg(1'b1, 16'd3);
    idle(3);
    chk("badbaud_rx_en", 32'(rx_en), 0);
    chk("badbaud_cpb", 32'(cpb), 3);
    set_cfg(1'b0, 16'd3);

    // Order and watermark
    @(negedge clk);
    cfg_wmark = 4'd3;
    step(1'b1, 8'hA5, 1'b0, 2'b00);
    chk("p1_level", 32'(rd_bus.level_o), 1);
    chk("p1_valid", 32'(rd_bus.rd_valid_o), 1);
    chk("p1_head", 32'(rd_bus.rd_data_o), 32'hA5);
    chk("p1_wmark", 32'(intr_wmark), 0);
    step(1'b1, 8'h3C, 1'b0, 2'b00);
    chk("p2_wmark", 32'(intr_wmark), 0);
    step(1'b1, 8'hFF, 1'b0, 2'b00);
    chk("p3_level", 32'(rd_bus.level_o), 3);
    chk("p3_wmark", 32'(intr_wmark), 1);
    chk("pop1_data", 32'(rd_bus.rd_data_o), 32'hA5);
    step(1'b0, 8'h00, 1'b1, 2'b00);
    chk("pop1_level", 32'(rd_bus.level_o), 2);
    chk("pop1_wmark", 32'(intr_wmark), 0);
    chk("pop2_data", 32'(rd_bus.rd_data_o), 32'h3C);
    step(1'b0, 8'h00, 1'b1, 2'b00);
    chk("pop3_data", 32'(rd_bus.rd_data_o), 32'hFF);
    step(1'b0, 8'h00, 1'b1, 2'b00);
    chk("pop3_level", 32'(rd_bus.level_o), 0);
    chk("pop3_valid", 32'(rd_bus.rd_valid_o), 0);
    step(1'b0, 8'h00, 1'b1, 2'b00);
    chk("empty_pop_level", 32'(rd_bus.level_o), 0);
    chk("empty_pop_valid", 32'(rd_bus.rd_valid_o), 0);

    // Overflow
    @(negedge clk);
    cfg_wmark = 4'd0;
    for (int i = 0; i < 9; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 2'b00);
    chk("ovf_level", 32'(rd_bus.level_o), 8);
    chk("ovf_flag", 32'(intr_overflow), 1);
    chk("ovf_wmark_off", 32'(intr_wmark), 0);
    step(1'b0, 8'h00, 1'b0, 2'b01);
    chk("ovf_clr", 32'(intr_overflow), 0);
    step(1'b1, 8'h20, 1'b1, 2'b00);
    chk("full_pp_level", 32'(rd_bus.level_o), 8);
    chk("full_pp_ovf", 32'(intr_overflow), 0);
    step(1'b1, 8'h21, 1'b0, 2'b01);
    chk("set_beats_clr", 32'(intr_overflow), 1);
    step(1'b0, 8'h00, 1'b0, 2'b01);
    chk("ovf_clr2", 32'(intr_overflow), 0);
    for (int i = 0; i < 7; i++) begin
      chk("drain_data", 32'(rd_bus.rd_data_o), 32'(8'h11 + i));
      step(1'b0, 8'h00, 1'b1, 2'b00);
    end
    chk("drain_last", 32'(rd_bus.rd_data_o), 32'h20);
    step(1'b0, 8'h00, 1'b1, 2'b00);
    chk("drain_level", 32'(rd_bus.level_o), 0);

    // Idle timeout
    @(negedge clk);
    cfg_timeout = 8'd4;
    set_cfg(1'b1, 16'd10);
    chk("to_cpb", 32'(cpb), 10);
    step(1'b1, 8'h5A, 1'b0, 2'b00);
    idle(39);
    chk("to_before", 32'(intr_timeout), 0);
    idle(1);
    chk("to_set", 32'(intr_timeout), 1);
    step(1'b0, 8'h00, 1'b0, 2'b10);
    chk("to_clr", 32'(intr_timeout), 0);
    idle(60);
    chk("to_no_retrig", 32'(intr_timeout), 0);
    step(1'b0, 8'h00, 1'b1, 2'b00);
    idle(100);
    chk("to_empty", 32'(intr_timeout), 0);

    // Disable with a frame in flight, then reset with bytes queued
    set_cfg(1'b0, 16'd10);
    chk("late_rx_en", 32'(rx_en), 0);
    step(1'b1, 8'h77, 1'b0, 2'b00);
    chk("late_level", 32'(rd_bus.level_o), 1);
    chk("late_data", 32'(rd_bus.rd_data_o), 32'h77);
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h80 + i), 1'b0, 2'b00);
    @(negedge clk);
    cfg_wmark = 4'd3;
    #1;
    chk("pre_rst_level", 32'(rd_bus.level_o), 5);
    chk("pre_rst_wmark", 32'(intr_wmark), 1);
    rst_ni = 1'b0;
    #1;
    chk("arst_level", 32'(rd_bus.level_o), 0);
    chk("arst_valid", 32'(rd_bus.rd_valid_o), 0);
    chk("arst_data", 32'(rd_bus.rd_data_o), 0);
    chk("arst_cpb", 32'(cpb), 0);
    chk("arst_intr", 32'({intr_wmark, intr_overflow, intr_timeout}), 0);
    idle(2);
    @(negedge clk);
    rst_ni = 1'b1;
    idle(2);
    chk("post_rst_level", 32'(rd_bus.level_o), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Receive-side controller for the UART receiver. It holds the configuration the receiver consumes: enable and clocks-per-bit. It buffers each received byte in a small first-word-fall-through FIFO and raises watermark, overflow and idle-timeout interrupts. It sits between the uart_rx datapath and the peripheral register/bus layer.

## Interface
- DEPTH, 8, FIFO entries; power of two, ≥2; AW = log2(DEPTH)
- clk_i  in  1  system clock
- rst_ni  in  1  reset, asynchronous, active-low
- cfg_en_i  in  1  receiver enable request
- cfg_baud_i  in  16  clocks per bit requested
- cfg_wmark_i  in  AW+1  watermark level; 0 disables the watermark interrupt
- cfg_timeout_i  in  8  idle bit-times before timeout; 0 disables the timeout
- clr_i  in  2  clear sticky flags: [0] overflow, [1] timeout (one-cycle pulses)
- rx_en_o  out  1  enable to uart_rx
- clks_per_bit_o  out  16  CLKS_PER_BIT to uart_rx
- rx_dv_i  in  1  byte-valid pulse from uart_rx
- rx_byte_i  in  8  received byte from uart_rx
- rd_req_i  in  1  pop request
- rd_data_o  out  8  FIFO head; valid only while rd_valid_o is high
- rd_valid_o  out  1  FIFO not empty
- level_o  out  AW+1  FIFO occupancy, 0..DEPTH
- intr_wmark_o  out  1  level_o ≥ cfg_wmark_i, and cfg_wmark_i ≠ 0
- intr_overflow_o  out  1  sticky: a byte was dropped
- intr_timeout_o  out  1  sticky: idle timeout occurred

## Operation
- **Reset values:** rx_en_o=0, clks_per_bit_o=0, level_o=0, rd_valid_o=0, rd_data_o=0, all interrupts 0, FSM=S_OFF, timers 0.
- **FSM S_OFF:** rx_en_o=0. The shadow baud register loads cfg_baud_i every cycle. Go to S_ON when cfg_en_i=1 and cfg_baud_i ≥ 4.
  - If cfg_en_i=1 with cfg_baud_i < 4, stay in S_OFF.
- **FSM S_ON:** rx_en_o=1. The shadow baud register is frozen. Go to S_OFF when cfg_en_i=0.
- **Frames in flight:** rx_dv_i is accepted in any state. A frame that started before disable still completes and is stored.
- **Push:** on rx_dv_i, rx_byte_i is written at the tail.
  - If the FIFO is full and there is no pop in the same cycle, the byte is dropped and overflow is set.
- **Pop:** rd_req_i with rd_valid_o=1 advances the head. rd_req_i while empty is ignored and has no side effects.
- **Simultaneous push and pop:** both execute and level_o is unchanged. At full, the push is accepted (no overflow). At empty, the pop is ignored and the push proceeds.
- **Sticky flags:** set has priority over clr_i in the same cycle. The flags are not affected by cfg_en_i.
- **Timeout timer:**
  - A prescaler counts 0..clks_per_bit_o-1. Each wrap increments an 8-bit bit-time counter, which saturates.
  - Both counters reset on rx_dv_i, on an accepted pop, or while the FIFO is empty.
  - When the bit-time counter equals cfg_timeout_i (≠0) with the FIFO non-empty, intr_timeout_o is set. It fires once per idle period and re-arms only after a counter reset.
- **Arithmetic:** pointers are AW bits and wrap modulo DEPTH. level_o is AW+1 bits. All compares are unsigned.

## Timing
- rx_dv_i in cycle N: level_o and rd_valid_o update in N+1. rd_data_o shows the byte in N+1 if the FIFO was empty.
- Accepted pop in cycle N: the new head appears on rd_data_o in N+1.
- cfg_en_i rises in cycle N (baud valid): rx_en_o=1 in N+1, and clks_per_bit_o holds the value sampled in N.
- cfg_en_i falls in cycle N: rx_en_o=0 in N+1.
- Overflow/timeout set in cycle N: the interrupt is visible in N+1. A clear in N takes effect in N+1.
- intr_wmark_o is combinational from the registered level_o; no extra latency.
- Asynchronous reset mid-frame or mid-timer returns all state to the reset values immediately, and the FIFO contents are discarded.

## Structure
- Shared package uart_pkg holds:
  - state encodings S_OFF/S_ON;
  - MIN_BAUD=4;
  - DEPTH default.
- One sub-module, uart_rx_fifo: a synchronous FWFT FIFO with push, pop, full, empty and level.
- The FSM, baud shadow, timeout timer and sticky flags live in uart_rx_ctrl.

## Test plan
- **Enable/baud:** cfg_baud_i=87, cfg_en_i=1 → clks_per_bit_o=87 and rx_en_o=1 next cycle. Change cfg_baud_i to 20 while enabled → output stays 87. Disable → rx_en_o=0, then 20 is loaded.
- **Invalid baud:** cfg_baud_i=3, cfg_en_i=1 → rx_en_o stays 0.
- **Order and watermark:** push 0xA5, 0x3C, 0xFF with wmark=3 → intr_wmark_o rises after the third push. Pops return A5, 3C, FF in order. level_o goes 3→0 and intr_wmark_o falls when level is 2.
- **Overflow:** DEPTH=8, push 9 bytes with no pop → level_o=8, intr_overflow_o=1, and the 9th byte is absent.
  - Push plus pop at full → no overflow, level stays 8.
  - clr_i[0] → the flag clears, unless a simultaneous drop sets it again.
- **Timeout:** baud=10, cfg_timeout_i=4, one byte pushed, no pop → intr_timeout_o sets 40 cycles after the push and does not retrigger. With an empty FIFO it never sets.
- **Reset and disable mid-operation:**
  - Assert rst_ni low with 5 bytes queued → level_o=0, all outputs at reset values.
  - Disable during a frame, then rx_dv_i → the byte is stored.
